// File: rtl/bsg_sram_1rw1r_ctrl_if.sv
// Request/response channels and macro pins of bsg_sram_1rw1r_ctrl.
// Suffixes (_i/_o) are named from the controller's point of view (slave modport).
interface bsg_sram_1rw1r_ctrl_if #(
    parameter int data_width_p = 8,
    parameter int addr_width_p = 10,
    parameter int mask_width_p = data_width_p / 8
);
    logic                    v0_i;
    logic                    ready0_o;
    logic                    w0_i;
    logic [addr_width_p-1:0] addr0_i;
    logic [data_width_p-1:0] data0_i;
    logic [mask_width_p-1:0] mask0_i;
    logic                    v0_o;
    logic [data_width_p-1:0] data0_o;
    logic                    yumi0_i;
    logic                    v1_i;
    logic                    ready1_o;
    logic [addr_width_p-1:0] addr1_i;
    logic                    v1_o;
    logic [data_width_p-1:0] data1_o;
    logic                    yumi1_i;
    logic                    csb0_o;
    logic                    web0_o;
    logic [mask_width_p-1:0] wmask0_o;
    logic [addr_width_p-1:0] addr0_o;
    logic [data_width_p-1:0] din0_o;
    logic [data_width_p-1:0] dout0_i;
    logic                    csb1_o;
    logic [addr_width_p-1:0] addr1_o;
    logic [data_width_p-1:0] dout1_i;

    modport slave (
        input  v0_i, w0_i, addr0_i, data0_i, mask0_i, yumi0_i,
        input  v1_i, addr1_i, yumi1_i, dout0_i, dout1_i,
        output ready0_o, v0_o, data0_o, ready1_o, v1_o, data1_o,
        output csb0_o, web0_o, wmask0_o, addr0_o, din0_o, csb1_o, addr1_o
    );

    modport master (
        output v0_i, w0_i, addr0_i, data0_i, mask0_i, yumi0_i,
        output v1_i, addr1_i, yumi1_i, dout0_i, dout1_i,
        input  ready0_o, v0_o, data0_o, ready1_o, v1_o, data1_o,
        input  csb0_o, web0_o, wmask0_o, addr0_o, din0_o, csb1_o, addr1_o
    );
endinterface

// File: rtl/bsg_sram_1rw1r_ctrl.sv
// Controller for the 1rw1r OpenRAM macro: valid/ready requests to macro pins, per-port response FIFOs.
// Define BSG_SRAM_CTRL_COLLISION_FWD_EN to forward full-mask write data to a colliding port 1 read.
module bsg_sram_1rw1r_ctrl #(
    parameter int data_width_p = 8,
    parameter int addr_width_p = 10,
    parameter int mask_width_p = data_width_p / 8,
    parameter int fifo_els_p   = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bsg_sram_1rw1r_ctrl_if.slave bus
);
    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam int sum_w_lp = cnt_w_lp + 1;

    logic                    en_q, en_d;
    logic [1:0]              credit;
    logic [1:0]              rd_acc;
    logic [1:0]              yumi;
    logic [1:0]              fifo_v;
    logic [data_width_p-1:0] enq_data  [2];
    logic [data_width_p-1:0] head_data [2];
    logic                    ready0, ready1, wr_acc0, collide, stall1;

    // en_q keeps both channels closed until the first edge after reset release
    always_comb begin
        en_d    = 1'b1;
        ready0  = en_q & credit[0];
        wr_acc0 = bus.v0_i & ready0 & bus.w0_i;
        collide = wr_acc0 & bus.v1_i & (bus.addr0_i == bus.addr1_i);
`ifdef BSG_SRAM_CTRL_COLLISION_FWD_EN
        stall1  = collide & ~(&bus.mask0_i);
`else
        stall1  = collide;
`endif
        ready1    = en_q & credit[1] & ~stall1;
        rd_acc[0] = bus.v0_i & ready0 & ~bus.w0_i;
        rd_acc[1] = bus.v1_i & ready1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) en_q <= 1'b0;
        else            en_q <= en_d;
    end

    assign yumi        = {bus.yumi1_i, bus.yumi0_i};
    assign enq_data[0] = bus.dout0_i;

`ifdef BSG_SRAM_CTRL_COLLISION_FWD_EN
    // Macro output is undefined on a collision, so the written word stands in for dout1
    logic                    fwd_q, fwd_d;
    logic [data_width_p-1:0] fwd_data_q, fwd_data_d;

    always_comb begin
        fwd_d      = rd_acc[1] & collide;
        fwd_data_d = fwd_data_q;
        if (fwd_d) fwd_data_d = bus.data0_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) fwd_q <= 1'b0;
        else            fwd_q <= fwd_d;
    end

    always_ff @(posedge clk_i) begin
        fwd_data_q <= fwd_data_d;
    end

    assign enq_data[1] = fwd_q ? fwd_data_q : bus.dout1_i;
`else
    assign enq_data[1] = bus.dout1_i;
`endif

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [data_width_p-1:0] mem_q [fifo_els_p];
        logic [ptr_w_lp-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [cnt_w_lp-1:0]     count_q, count_d;
        logic                    inflight_q, inflight_d;
        logic                    enq, deq;

        // Read data from the macro lands in the FIFO one edge after acceptance
        always_comb begin
            enq        = inflight_q;
            deq        = yumi[p] & (count_q != '0);
            inflight_d = rd_acc[p];
            wr_ptr_d   = wr_ptr_q;
            rd_ptr_d   = rd_ptr_q;
            if (enq) wr_ptr_d = (wr_ptr_q == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_q + ptr_w_lp'(1);
            if (deq) rd_ptr_d = (rd_ptr_q == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_q + ptr_w_lp'(1);
            count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                inflight_q <= 1'b0;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                count_q    <= count_d;
                inflight_q <= inflight_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (enq) mem_q[wr_ptr_q] <= enq_data[p];
        end

        assign credit[p]    = (sum_w_lp'(count_q) + sum_w_lp'(inflight_q)) < sum_w_lp'(fifo_els_p);
        assign fifo_v[p]    = (count_q != '0);
        assign head_data[p] = mem_q[rd_ptr_q];
    end

    assign bus.ready0_o = ready0;
    assign bus.ready1_o = ready1;
    assign bus.csb0_o   = ~(bus.v0_i & ready0);
    assign bus.web0_o   = ~bus.w0_i;
    assign bus.wmask0_o = bus.mask0_i;
    assign bus.addr0_o  = bus.addr0_i;
    assign bus.din0_o   = bus.data0_i;
    assign bus.csb1_o   = ~(bus.v1_i & ready1);
    assign bus.addr1_o  = bus.addr1_i;
    assign bus.v0_o     = fifo_v[0];
    assign bus.v1_o     = fifo_v[1];
    assign bus.data0_o  = fifo_v[0] ? head_data[0] : '0;
    assign bus.data1_o  = fifo_v[1] ? head_data[1] : '0;
endmodule

// File: tb/tb_bsg_sram_1rw1r_ctrl.sv
// Randomized scoreboard bench for bsg_sram_1rw1r_ctrl with a behavioural 1rw1r macro model.
module tb_bsg_sram_1rw1r_ctrl;
    localparam int DW  = 8;
    localparam int AW  = 10;
    localparam int ELS = 3;

    typedef struct {
        logic [DW-1:0] data;
        int            edge_n;
    } rsp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bsg_sram_1rw1r_ctrl_if #(.data_width_p(DW), .addr_width_p(AW)) bus_if ();

    bsg_sram_1rw1r_ctrl #(.data_width_p(DW), .addr_width_p(AW), .fifo_els_p(ELS)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus_if)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rdy_ok   = 1'b0;
    bit   ymode0   = 1'b0;
    bit   ymode1   = 1'b0;
    rsp_t q0[$];
    rsp_t q1[$];
    logic [DW-1:0] ref_mem [1<<AW];

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a) ^ 8'h3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // Macro model: registered dout, undefined port 1 data on same-address write
    logic [DW-1:0] mac_mem [1<<AW];
    bit            mac_wr  [1<<AW];
    always @(posedge clk) begin
        if (!bus_if.csb1_o) begin
            if (!bus_if.csb0_o && !bus_if.web0_o && bus_if.addr0_o == bus_if.addr1_o)
                bus_if.dout1_i <= DW'($urandom);
            else
                bus_if.dout1_i <= mac_wr[bus_if.addr1_o] ? mac_mem[bus_if.addr1_o] : init_val(int'(bus_if.addr1_o));
        end
        if (!bus_if.csb0_o) begin
            if (!bus_if.web0_o) begin
                if (bus_if.wmask0_o[0]) begin
                    mac_mem[bus_if.addr0_o] <= bus_if.din0_o;
                    mac_wr[bus_if.addr0_o]  <= 1'b1;
                end
            end else begin
                bus_if.dout0_i <= mac_wr[bus_if.addr0_o] ? mac_mem[bus_if.addr0_o] : init_val(int'(bus_if.addr0_o));
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: credit/pin expectations from queue occupancy, response order and latency from the scoreboard
    bit er0, er1, coll, st, v0e, v1e;
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_ready0", bus_if.ready0_o, 0);
            chk("rst_ready1", bus_if.ready1_o, 0);
            chk("rst_csb0", bus_if.csb0_o, 1);
            chk("rst_csb1", bus_if.csb1_o, 1);
            chk("rst_v0", bus_if.v0_o, 0);
            chk("rst_v1", bus_if.v1_o, 0);
            chk("rst_data0", bus_if.data0_o, 0);
            chk("rst_data1", bus_if.data1_o, 0);
        end else begin
            er0  = rdy_ok && q0.size() < ELS;
            coll = bus_if.v0_i && bus_if.w0_i && er0 && bus_if.v1_i && (bus_if.addr0_i == bus_if.addr1_i);
`ifdef BSG_SRAM_CTRL_COLLISION_FWD_EN
            st = coll && (bus_if.mask0_i != 1'b1);
`else
            st = coll;
`endif
            er1 = rdy_ok && q1.size() < ELS && !st;
            chk("ready0", bus_if.ready0_o, er0);
            chk("ready1", bus_if.ready1_o, er1);
            chk("csb0", bus_if.csb0_o, !(bus_if.v0_i && er0));
            chk("csb1", bus_if.csb1_o, !(bus_if.v1_i && er1));
            if (bus_if.v0_i) chk("web0", bus_if.web0_o, !bus_if.w0_i);
            v0e = q0.size() > 0 && (q0[0].edge_n + 1 <= cyc);
            v1e = q1.size() > 0 && (q1[0].edge_n + 1 <= cyc);
            chk("v0", bus_if.v0_o, v0e);
            chk("v1", bus_if.v1_o, v1e);
            if (v0e) chk("data0", bus_if.data0_o, q0[0].data);
            if (v1e) chk("data1", bus_if.data1_o, q1[0].data);
            if (v0e && bus_if.yumi0_i) void'(q0.pop_front());
            if (v1e && bus_if.yumi1_i) void'(q1.pop_front());
        end
    end

    task automatic drive(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit m0, input bit v1, input logic [AW-1:0] a1,
                         output bit acc0, output bit acc1);
        rsp_t r;
        @(posedge clk);
        #1;
        bus_if.v0_i    = v0;
        bus_if.w0_i    = w0;
        bus_if.addr0_i = a0;
        bus_if.data0_i = d0;
        bus_if.mask0_i = m0;
        bus_if.v1_i    = v1;
        bus_if.addr1_i = a1;
        bus_if.yumi0_i = ymode0 & bus_if.v0_o;
        bus_if.yumi1_i = ymode1 & bus_if.v1_o;
        #6;
        acc0 = v0 && bus_if.ready0_o;
        acc1 = v1 && bus_if.ready1_o;
        // A write lands before a same-cycle port 1 read is served
        if (acc0 && w0 && m0) ref_mem[a0] = d0;
        if (acc0 && !w0) begin
            r.data = ref_mem[a0]; r.edge_n = cyc + 1; q0.push_back(r);
        end
        if (acc1) begin
            r.data = ref_mem[a1]; r.edge_n = cyc + 1; q1.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        bit x0, x1;
        for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, x0, x1);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        rdy_ok = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit a0, a1, saw_stall;
        int idx, n;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
        bus_if.v0_i = 0; bus_if.w0_i = 0; bus_if.addr0_i = '0; bus_if.data0_i = '0;
        bus_if.mask0_i = '0; bus_if.v1_i = 1'b1; bus_if.addr1_i = '0;
        bus_if.yumi0_i = 0; bus_if.yumi1_i = 0;
        repeat (3) @(posedge clk);
        bus_if.v1_i = 0;
        release_reset();

        // Basic write then read
        ymode0 = 1; ymode1 = 1;
        drive(1, 1, 10'h3FF, 8'h5A, 1, 0, '0, a0, a1);
        chk("basic_wr_acc", a0, 1);
        drive(1, 0, 10'h3FF, '0, 1, 0, '0, a0, a1);
        chk("basic_rd_acc", a0, 1);
        idle(4);

        // Back-pressure on port 1
        for (int i = 0; i < 6; i++) drive(1, 1, AW'(i), DW'(8'h10 + i), 1, 0, '0, a0, a1);
        ymode1 = 0; idx = 0; saw_stall = 0;
        for (int c = 0; c < 60 && idx < 6; c++) begin
            if (c == 12) ymode1 = 1;
            drive(0, 0, '0, '0, 0, 1, AW'(idx), a0, a1);
            if (a1) idx++;
            else saw_stall = 1;
        end
        chk("bp_count", idx, 6);
        chk("bp_stalled", saw_stall, 1);
        idle(8);

        // Same-address collision
        drive(1, 1, 10'h020, 8'hA5, 1, 1, 10'h020, a0, a1);
        chk("coll_wr_acc", a0, 1);
`ifdef BSG_SRAM_CTRL_COLLISION_FWD_EN
        chk("coll_rd_acc", a1, 1);
`else
        chk("coll_rd_acc", a1, 0);
`endif
        n = 0;
        while (!a1 && n < 10) begin
            drive(0, 0, '0, '0, 0, 1, 10'h020, a0, a1);
            n++;
        end
        chk("coll_done", a1, 1);
        idle(4);

        // Mask-zero write leaves the word untouched
        drive(1, 1, 10'h055, 8'h77, 1, 0, '0, a0, a1);
        drive(1, 1, 10'h055, 8'h11, 0, 0, '0, a0, a1);
        drive(1, 0, 10'h055, '0, 0, 1, 10'h055, a0, a1);
        idle(4);

        // Dual-port read throughput
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, AW'($urandom), '0, 0, 1, AW'($urandom), a0, a1);
            chk("tp_acc", {a0, a1}, 2'b11);
        end
        idle(4);

        // Reset with two reads outstanding
        drive(1, 0, 10'h3FF, '0, 0, 1, 10'h005, a0, a1);
        drive(1, 0, 10'h001, '0, 0, 1, 10'h002, a0, a1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        q0.delete(); q1.delete(); rdy_ok = 1'b0;
        #1;
        chk("midrst_v0", bus_if.v0_o, 0);
        chk("midrst_v1", bus_if.v1_o, 0);
        chk("midrst_csb0", bus_if.csb0_o, 1);
        chk("midrst_csb1", bus_if.csb1_o, 1);
        bus_if.v0_i = 0; bus_if.v1_i = 0;
        repeat (2) @(posedge clk);
        release_reset();
        idle(6);

        // Randomized mix on a small address window
        for (int i = 0; i < 300; i++) begin
            ymode0 = ($urandom_range(3) != 0);
            ymode1 = ($urandom_range(3) != 0);
            drive($urandom_range(1), $urandom_range(1), AW'($urandom_range(7)), DW'($urandom),
                  $urandom_range(1), $urandom_range(1), AW'($urandom_range(7)), a0, a1);
        end
        ymode0 = 1; ymode1 = 1;
        idle(10);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bsg_sram_1rw1r_ctrl.md
# bsg_sram_1rw1r_ctrl

Initiator-side controller for the 1rw1r OpenRAM SRAM macro (default geometry 8x1024, one byte write mask). It converts two valid/ready request channels into the macro's active-low chip-select/write-enable pin protocol, one channel per macro port. It captures the macro's read data into per-port response FIFOs so downstream stalls never lose data. It sits between the tile memory logic and the macro and owns all same-address collision handling.

## Interface
- `data_width_p`, default 8: SRAM word width.
- `addr_width_p`, default 10: SRAM address width.
- `mask_width_p`, default `data_width_p/8`: write-mask bits, one per byte.
- `fifo_els_p`, default 3: response FIFO depth per port, minimum 2. A depth of 3 sustains one read per cycle.
- `clk_i` in, 1: single clock. Also drives both macro clocks externally.
- `reset_n_i` in, 1: asynchronous, active-low reset.
- `v0_i` / `ready0_o` in/out, 1: port 0 request handshake.
- `w0_i` in, 1: 1 = write, 0 = read.
- `addr0_i` in, `addr_width_p`: port 0 address.
- `data0_i` in, `data_width_p`: port 0 write data.
- `mask0_i` in, `mask_width_p`: port 0 byte write mask.
- `v0_o` / `data0_o` / `yumi0_i` out/out/in, 1/`data_width_p`/1: port 0 read response.
- `v1_i` / `ready1_o` / `addr1_i` in/out/in, 1/1/`addr_width_p`: port 1 read request.
- `v1_o` / `data1_o` / `yumi1_i` out/out/in, 1/`data_width_p`/1: port 1 read response.
- `csb0_o`, `web0_o` out, 1 each: macro port 0 chip select and write enable, both active-low.
- `wmask0_o` out, `mask_width_p`: macro port 0 write mask.
- `addr0_o` out, `addr_width_p`: macro port 0 address.
- `din0_o` out, `data_width_p`: macro port 0 write data.
- `dout0_i` in, `data_width_p`: macro port 0 read data.
- `csb1_o` out, 1: macro port 1 chip select, active-low.
- `addr1_o` out, `addr_width_p`: macro port 1 address.
- `dout1_i` in, `data_width_p`: macro port 1 read data.

## Operation
- **Acceptance:** a request is accepted on a clock edge where `v & ready` is high.
- **Pin drive (combinational from the request):**
  - `csb0_o = ~(v0_i & ready0_o)`
  - `web0_o = ~w0_i`
  - `wmask0_o = mask0_i`
  - `addr0_o = addr0_i`
  - `din0_o = data0_i`
  - `csb1_o = ~(v1_i & ready1_o)`
  - `addr1_o = addr1_i`
- **Credit rule (per port):**
  - `ready_o = (fifo_count + inflight) < fifo_els_p`.
  - `fifo_count` and `inflight` are registered; `ready_o` does not depend on `yumi`.
  - Port 0 applies the same rule to writes (conservative).
- **Read flow:**
  - An accepted read sets `inflight`.
  - On the next edge, the macro `dout` is enqueued into the port's FIFO and `inflight` clears, unless a new read is accepted on that same edge.
- **Writes:** no response, no `inflight`.
- **Response FIFO:**
  - `v_o` is high when the FIFO is non-empty; `data_o` is the head entry.
  - `yumi_i` pops the head and is only legal while `v_o` is high.
  - Enqueue and dequeue in the same cycle leave the count unchanged.
- **Collision:** a port 0 write and a port 1 read to the same address in the same cycle is a collision. The macro output is undefined for it. Without the configuration macro, `ready1_o` is forced to 0 for that cycle and the write proceeds.
- **Port 0 read vs port 1 read, same address:** no hazard, both accepted.
- **Reset (asserted at any time, including with reads in flight):**
  - FIFOs, `inflight` and forward state clear.
  - `ready0_o = ready1_o = 0`, so `csb0_o = csb1_o = 1`.
  - `v0_o = v1_o = 0`; `data0_o = data1_o = 0`.
  - `web0_o` follows `w0_i`, but is irrelevant while `csb0_o = 1`.
  - Responses outstanding at reset are dropped.

## Timing
- **Read latency:** request accepted at edge N; macro `dout` valid during cycle N+1; enqueued at edge N+1; `v_o` high in cycle N+2. No bypass path.
- **Throughput:** one read per cycle per port with `fifo_els_p >= 3` and `yumi` held high.
- **Write timing:** data is in the array after edge N. A port 0 read of the same address accepted at edge N+1 returns the new data.
- **Reset timing:** `reset_n_i` asserts asynchronously. Release is sampled at an edge, and `ready` rises in the first cycle after release.

## Configuration
- **`BSG_SRAM_CTRL_COLLISION_FWD_EN` defined:**
  - A collision with `mask0_i` all ones does not stall; port 1 is accepted.
  - `data0_i` is registered, and that value replaces `dout1_i` at enqueue.
  - Port 1 returns the newly written data.
  - A partial-mask collision still stalls port 1.
- **`BSG_SRAM_CTRL_COLLISION_FWD_EN` undefined:** every collision stalls port 1 for one cycle, as described in Operation.

## Test plan
- **Basic write then read:** write `0x5A` to `0x3FF` with mask `1`; read `0x3FF` on port 0 next cycle with `yumi0_i = 1` -> `v0_o` high 2 cycles after accept with `data0_o = 0x5A`.
- **Back-pressure:** stream 6 port 1 reads (addresses 0..5, preloaded `0x10..0x15`) with `yumi1_i = 0`.
  - `ready1_o` drops once 3 are outstanding, and `csb1_o` stays 1 while stalled.
  - After releasing `yumi1_i`, data returns `0x10..0x15` in order with no loss.
- **Collision:** port 0 write of `0xA5` to `0x020` with port 1 read of `0x020` in the same cycle.
  - Without the macro: `ready1_o = 0` that cycle, and the retried read returns `0xA5`.
  - With the macro: accepted, and returns `0xA5` at latency 2.
- **Dual-port throughput:** simultaneous port 0 and port 1 reads every cycle for 16 cycles with `yumi` high -> both ports return 16 correct words, `ready` never drops.
- **Mid-flight reset:** assert `reset_n_i` low with 2 reads in flight -> `v0_o = v1_o = 0`, `csb0_o = csb1_o = 1` immediately; no stale response appears after release.
- **Mask-zero write:** write with `mask0_i = 0` to a location holding `0x77` -> a later read returns `0x77`.
